maindec_pipe: RTL and testbench
===============================

Name: maindec_pipe

Overview:
- Registered, parametrised main decoder for the MIPS core's ID stage. It decodes op/funct into the control word and holds it in an output register with a valid/ready handshake.
- Adds multi-cycle sequencing for MULT/MULTU/DIV/DIVU. While one of these is in flight the block is busy and back-pressures fetch.
- Flags reserved instructions and supports a synchronous pipeline flush.

Parameters:
- ALUOP_W, 4, width of aluop field; codes come from the shared defines header.
- MUL_CYCLES, 3, cycles from MULT/MULTU accept to out_valid (>=1).
- DIV_CYCLES, 32, cycles from DIV/DIVU accept to out_valid (>=1).
- CNT_W, 6, busy counter width; must satisfy 2^CNT_W > max(MUL_CYCLES, DIV_CYCLES).

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- in_valid  in  1  op/funct valid this cycle.
- in_ready  out  1  block accepts op/funct this cycle.
- op  in  6  instruction[31:26].
- funct  in  6  instruction[5:0].
- flush  in  1  synchronous kill of held/in-flight instruction.
- out_valid  out  1  control word valid.
- out_ready  in  1  EX stage consumes control word.
- regwrite, regdst, branch, memwrite, memtoreg, jump, link  out  1 each  control bits.
- alusrc  out  2  ALU B source (00 reg, 01 sign-imm, 10 zero-imm).
- hilowrite  out  2  {hi_we, lo_we}.
- aluop  out  ALUOP_W  ALU operation class.
- invalid_instr  out  1  reserved-instruction flag, qualified by out_valid.
- busy  out  1  multi-cycle op in progress.

Behaviour:
- Reset (resetn=0, async): state=IDLE, out_valid=0, busy=0, counter=0, all control outputs=0, invalid_instr=0.
- States:
  - IDLE: output register empty.
  - BUSY: multi-cycle op counting.
  - FULL: out_valid=1, waiting for out_ready.
- in_ready = (state==IDLE) || (state==FULL && out_ready). It is 0 in BUSY. Accept = in_valid && in_ready.
- Decode table, bits {regwrite,regdst,alusrc,branch,memwrite,memtoreg,jump,link,hilowrite}:
  - R-type default: 1,1,00,0,0,0,0,0,00.
  - MFHI/MFLO: 1,1,00,0,0,0,0,0,00.
  - MTHI (010001): 0,0,00,0,0,0,0,0,10.
  - MTLO (010011): 0,0,00,0,0,0,0,0,01.
  - MULT/MULTU/DIV/DIVU (011000/011001/011010/011011): 0,0,00,0,0,0,0,0,11.
  - JR (001000): 0,0,00,0,0,0,1,0,00.
  - ANDI/ORI/XORI/LUI: 1,0,10,0,0,0,0,0,00.
  - ADDI/ADDIU/SLTI: 1,0,01,0,0,0,0,0,00.
  - LW: 1,0,01,0,0,1,0,0,00.
  - SW: 0,0,01,0,1,0,0,0,00.
  - BEQ/BNE (000100/000101): 0,0,00,1,0,0,0,0,00.
  - J: 0,0,00,0,0,0,1,0,00.
  - JAL (000011): 1,0,00,0,0,0,1,1,00.
  - Any other op: all 0, aluop=0, invalid_instr=1.
- aluop per op from the defines header; every R-type uses R_TYPE_OP.
- Latency, single-cycle op: accept at edge N, out_valid=1 after edge N (state FULL).
- Latency, multi-cycle op: the control word is registered at accept; state=BUSY, busy=1, counter=LAT-1, out_valid=0. Counter decrements each cycle. The edge where counter==0 moves to FULL, clears busy and sets out_valid. out_valid therefore rises exactly LAT cycles after accept. LAT=1 goes straight to FULL.
- FULL with out_ready=1 and no accept → IDLE, out_valid=0. FULL with out_ready=1 and accept → back-to-back load, no bubble.
- Control outputs hold their value while out_valid=0. The consumer qualifies with out_valid.
- Flush has priority over everything. On the next edge: state=IDLE, out_valid=0, busy=0, counter=0. A simultaneous accept is dropped and a BUSY count is aborted. Control outputs are not cleared.
- Mid-operation reset: async return to reset values regardless of state.

Test Plan:
- Reset then LW (op=100011) with in_valid=1, out_ready=1 → next cycle out_valid=1, regwrite=1, alusrc=01, memtoreg=1, other bits 0, invalid_instr=0.
- DIV (op=0, funct=011010) accepted with DIV_CYCLES=32 → busy=1 and in_ready=0 for 32 cycles; out_valid rises exactly 32 cycles after accept with hilowrite=11.
- FULL with out_ready=0 for 5 cycles, in_valid=1 → in_ready=0, outputs stable. Then out_ready=1 with ADDI waiting → ADDI loads on the same edge, out_valid stays 1.
- MULT accepted, flush asserted 2 cycles later → next edge busy=0, out_valid=0, in_ready=1; no late out_valid.
- op=111111 → out_valid=1, invalid_instr=1, regwrite=memwrite=branch=jump=0.
- JAL (000011) → regwrite=1, jump=1, link=1. MTHI → hilowrite=10, regwrite=0.

Source files
------------

// File: rtl/maindec_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module      : maindec_pipe_if
//  Description : Handshake and control-word bundle between fetch/ID, the
//                registered main decoder and the EX stage.
//  Revision    : 1.0 - initial release
// ============================================================================
interface maindec_pipe_if #(
    parameter int ALUOP_W = 4
);
    logic               in_valid;
    logic               in_ready;
    logic [5:0]         op;
    logic [5:0]         funct;
    logic               flush;
    logic               out_valid;
    logic               out_ready;
    logic               regwrite;
    logic               regdst;
    logic [1:0]         alusrc;
    logic               branch;
    logic               memwrite;
    logic               memtoreg;
    logic               jump;
    logic               link;
    logic [1:0]         hilowrite;
    logic [ALUOP_W-1:0] aluop;
    logic               invalid_instr;
    logic               busy;

    // Pipeline side: supplies instructions, flush and EX back-pressure.
    modport master (
        output in_valid, op, funct, flush, out_ready,
        input  in_ready, out_valid, regwrite, regdst, alusrc, branch,
               memwrite, memtoreg, jump, link, hilowrite, aluop,
               invalid_instr, busy
    );

    // Decoder side.
    modport slave (
        input  in_valid, op, funct, flush, out_ready,
        output in_ready, out_valid, regwrite, regdst, alusrc, branch,
               memwrite, memtoreg, jump, link, hilowrite, aluop,
               invalid_instr, busy
    );
endinterface
`default_nettype wire

// File: rtl/maindec_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : maindec_pipe
//  Description : Registered MIPS main decoder with valid/ready handshake,
//                multi-cycle sequencing for MULT/MULTU/DIV/DIVU, reserved
//                instruction flagging and synchronous flush.
//  Revision    : 1.0 - initial release
// ============================================================================
module maindec_pipe #(
    parameter int ALUOP_W    = 4,
    parameter int MUL_CYCLES = 3,
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  wire            clk,
    input  wire            resetn,
    maindec_pipe_if.slave  bus
);

    // ALU operation classes shared with the ALU decoder.
    localparam logic [ALUOP_W-1:0] c_ALU_NOP   = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] c_ALU_ADD   = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] c_ALU_ADDU  = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] c_ALU_SLT   = ALUOP_W'(3);
    localparam logic [ALUOP_W-1:0] c_ALU_AND   = ALUOP_W'(4);
    localparam logic [ALUOP_W-1:0] c_ALU_OR    = ALUOP_W'(5);
    localparam logic [ALUOP_W-1:0] c_ALU_XOR   = ALUOP_W'(6);
    localparam logic [ALUOP_W-1:0] c_ALU_LUI   = ALUOP_W'(7);
    localparam logic [ALUOP_W-1:0] c_ALU_SUB   = ALUOP_W'(8);
    localparam logic [ALUOP_W-1:0] c_ALU_RTYPE = ALUOP_W'(9);

    // Counter load values: the count runs LAT-1 .. 0, so LAT=1 loads zero
    // and goes straight to FULL.
    localparam logic [CNT_W-1:0] c_MUL_CNT = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_DIV_CNT = CNT_W'(DIV_CYCLES - 1);

    typedef struct packed {
        logic               regwrite;
        logic               regdst;
        logic [1:0]         alusrc;
        logic               branch;
        logic               memwrite;
        logic               memtoreg;
        logic               jump;
        logic               link;
        logic [1:0]         hilowrite;
        logic [ALUOP_W-1:0] aluop;
        logic               invalid;
    } ctrl_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_FULL = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    ctrl_t            r_ctrl;
    ctrl_t            w_dec;
    logic             w_accept;
    logic             w_load;
    logic             w_is_mdu;
    logic [CNT_W-1:0] w_lat_cnt;

    assign bus.in_ready = (r_state == S_IDLE) ||
                          ((r_state == S_FULL) && bus.out_ready);
    assign w_accept     = bus.in_valid && bus.in_ready;

    // MULT/MULTU/DIV/DIVU share funct 0110xx; funct[1] selects divide.
    assign w_is_mdu  = (bus.op == 6'b000000) && (bus.funct[5:2] == 4'b0110);
    assign w_lat_cnt = bus.funct[1] ? c_DIV_CNT : c_MUL_CNT;

    // Combinational decode of op/funct into the control word.
    always_comb begin
        w_dec = '0;
        case (bus.op)
            6'b000000: begin
                w_dec.aluop = c_ALU_RTYPE;
                casez (bus.funct)
                    6'b010001: w_dec.hilowrite = 2'b10;   // MTHI
                    6'b010011: w_dec.hilowrite = 2'b01;   // MTLO
                    6'b0110??: w_dec.hilowrite = 2'b11;   // MULT/MULTU/DIV/DIVU
                    6'b001000: w_dec.jump      = 1'b1;    // JR
                    default: begin                        // ALU ops, MFHI/MFLO
                        w_dec.regwrite = 1'b1;
                        w_dec.regdst   = 1'b1;
                    end
                endcase
            end
            6'b000010: begin                              // J
                w_dec.jump  = 1'b1;
                w_dec.aluop = c_ALU_NOP;
            end
            6'b000011: begin                              // JAL
                w_dec.regwrite = 1'b1;
                w_dec.jump     = 1'b1;
                w_dec.link     = 1'b1;
                w_dec.aluop    = c_ALU_NOP;
            end
            6'b000100, 6'b000101: begin                   // BEQ/BNE
                w_dec.branch = 1'b1;
                w_dec.aluop  = c_ALU_SUB;
            end
            6'b001000: begin                              // ADDI
                w_dec.regwrite = 1'b1;
                w_dec.alusrc   = 2'b01;
                w_dec.aluop    = c_ALU_ADD;
            end
            6'b001001: begin                              // ADDIU
                w_dec.regwrite = 1'b1;
                w_dec.alusrc   = 2'b01;
                w_dec.aluop    = c_ALU_ADDU;
            end
            6'b001010: begin                              // SLTI
                w_dec.regwrite = 1'b1;
                w_dec.alusrc   = 2'b01;
                w_dec.aluop    = c_ALU_SLT;
            end
            6'b001100: begin                              // ANDI
                w_dec.regwrite = 1'b1;
                w_dec.alusrc   = 2'b10;
                w_dec.aluop    = c_ALU_AND;
            end
            6'b001101: begin                              // ORI
                w_dec.regwrite = 1'b1;
                w_dec.alusrc   = 2'b10;
                w_dec.aluop    = c_ALU_OR;
            end
            6'b001110: begin                              // XORI
                w_dec.regwrite = 1'b1;
                w_dec.alusrc   = 2'b10;
                w_dec.aluop    = c_ALU_XOR;
            end
            6'b001111: begin                              // LUI
                w_dec.regwrite = 1'b1;
                w_dec.alusrc   = 2'b10;
                w_dec.aluop    = c_ALU_LUI;
            end
            6'b100011: begin                              // LW
                w_dec.regwrite = 1'b1;
                w_dec.alusrc   = 2'b01;
                w_dec.memtoreg = 1'b1;
                w_dec.aluop    = c_ALU_ADD;
            end
            6'b101011: begin                              // SW
                w_dec.alusrc   = 2'b01;
                w_dec.memwrite = 1'b1;
                w_dec.aluop    = c_ALU_ADD;
            end
            default: w_dec.invalid = 1'b1;                // reserved
        endcase
    end

    // Next-state, counter and load-enable logic; flush overrides everything.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_load      = 1'b0;
        if (bus.flush) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                S_IDLE, S_FULL: begin
                    if (w_accept) begin
                        w_load = 1'b1;
                        if (w_is_mdu && (w_lat_cnt != '0)) begin
                            w_state_nxt = S_BUSY;
                            w_cnt_nxt   = w_lat_cnt;
                        end else begin
                            w_state_nxt = S_FULL;
                        end
                    end else if ((r_state == S_FULL) && bus.out_ready) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                S_BUSY: begin
                    if (r_cnt == '0) begin
                        w_state_nxt = S_FULL;
                    end else begin
                        w_cnt_nxt = r_cnt - 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // State and busy counter registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Control word register; holds its value until the next accept.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ctrl <= '0;
        end else if (w_load) begin
            r_ctrl <= w_dec;
        end
    end

    assign bus.out_valid     = (r_state == S_FULL);
    assign bus.busy          = (r_state == S_BUSY);
    assign bus.regwrite      = r_ctrl.regwrite;
    assign bus.regdst        = r_ctrl.regdst;
    assign bus.alusrc        = r_ctrl.alusrc;
    assign bus.branch        = r_ctrl.branch;
    assign bus.memwrite      = r_ctrl.memwrite;
    assign bus.memtoreg      = r_ctrl.memtoreg;
    assign bus.jump          = r_ctrl.jump;
    assign bus.link          = r_ctrl.link;
    assign bus.hilowrite     = r_ctrl.hilowrite;
    assign bus.aluop         = r_ctrl.aluop;
    assign bus.invalid_instr = r_ctrl.invalid;

endmodule
`default_nettype wire

// File: tb/tb_maindec_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_maindec_pipe
//  Description : Self-checking bench for maindec_pipe: decode table vectors,
//                latency/stall/flush/reset sequences and random traffic
//                against a timestamp-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_maindec_pipe;

    localparam int ALUOP_W    = 4;
    localparam int MUL_CYCLES = 3;
    localparam int DIV_CYCLES = 32;
    localparam int CNT_W      = 6;

    localparam logic [3:0] c_NOP = 4'd0, c_ADD = 4'd1, c_ADDU = 4'd2,
                           c_SLT = 4'd3, c_AND = 4'd4, c_OR = 4'd5,
                           c_XOR = 4'd6, c_LUI = 4'd7, c_SUB = 4'd8,
                           c_RT  = 4'd9;

    typedef struct packed {
        logic       rw, rd;
        logic [1:0] as;
        logic       br, mw, mt, j, l;
        logic [1:0] hl;
        logic [3:0] alu;
        logic       inv;
    } exp_t;

    typedef struct {
        logic [5:0] op;
        logic [5:0] funct;
        exp_t       exp;
    } vec_t;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    maindec_pipe_if #(.ALUOP_W(ALUOP_W)) bus ();

    maindec_pipe #(
        .ALUOP_W(ALUOP_W), .MUL_CYCLES(MUL_CYCLES),
        .DIV_CYCLES(DIV_CYCLES), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: holds the expected word, whether it is presented,
    // and the absolute cycle at which a pending multi-cycle op completes.
    bit   m_full, m_pend;
    int   m_due, cyc;
    exp_t m_word;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input bit rw, rd, input bit [1:0] as, input bit br, mw, mt, j, l,
                                input bit [1:0] hl, input logic [3:0] alu, input bit inv);
        exp_t e;
        e = '{rw, rd, as, br, mw, mt, j, l, hl, alu, inv};
        return e;
    endfunction

    function automatic exp_t ref_decode(input logic [5:0] op, input logic [5:0] f);
        case (op)
            6'd0: begin
                if (f == 6'h11)              return mk(0,0,2'b00,0,0,0,0,0,2'b10,c_RT,0);
                if (f == 6'h13)              return mk(0,0,2'b00,0,0,0,0,0,2'b01,c_RT,0);
                if (f >= 6'h18 && f <= 6'h1b) return mk(0,0,2'b00,0,0,0,0,0,2'b11,c_RT,0);
                if (f == 6'h08)              return mk(0,0,2'b00,0,0,0,1,0,2'b00,c_RT,0);
                return mk(1,1,2'b00,0,0,0,0,0,2'b00,c_RT,0);
            end
            6'd2:  return mk(0,0,2'b00,0,0,0,1,0,2'b00,c_NOP,0);
            6'd3:  return mk(1,0,2'b00,0,0,0,1,1,2'b00,c_NOP,0);
            6'd4,
            6'd5:  return mk(0,0,2'b00,1,0,0,0,0,2'b00,c_SUB,0);
            6'd8:  return mk(1,0,2'b01,0,0,0,0,0,2'b00,c_ADD,0);
            6'd9:  return mk(1,0,2'b01,0,0,0,0,0,2'b00,c_ADDU,0);
            6'd10: return mk(1,0,2'b01,0,0,0,0,0,2'b00,c_SLT,0);
            6'd12: return mk(1,0,2'b10,0,0,0,0,0,2'b00,c_AND,0);
            6'd13: return mk(1,0,2'b10,0,0,0,0,0,2'b00,c_OR,0);
            6'd14: return mk(1,0,2'b10,0,0,0,0,0,2'b00,c_XOR,0);
            6'd15: return mk(1,0,2'b10,0,0,0,0,0,2'b00,c_LUI,0);
            6'd35: return mk(1,0,2'b01,0,0,1,0,0,2'b00,c_ADD,0);
            6'd43: return mk(0,0,2'b01,0,1,0,0,0,2'b00,c_ADD,0);
            default: return mk(0,0,2'b00,0,0,0,0,0,2'b00,c_NOP,1);
        endcase
    endfunction

    function automatic int ref_latency(input logic [5:0] op, input logic [5:0] f);
        if (op == 6'd0 && (f == 6'h18 || f == 6'h19)) return MUL_CYCLES;
        if (op == 6'd0 && (f == 6'h1a || f == 6'h1b)) return DIV_CYCLES;
        return 1;
    endfunction

    function automatic exp_t obs();
        exp_t e;
        e = '{bus.regwrite, bus.regdst, bus.alusrc, bus.branch, bus.memwrite,
              bus.memtoreg, bus.jump, bus.link, bus.hilowrite, bus.aluop,
              bus.invalid_instr};
        return e;
    endfunction

    task automatic model_reset();
        m_full = 0; m_pend = 0; m_due = 0; m_word = '0;
    endtask

    task automatic model_edge(input bit iv, input logic [5:0] op, f, input bit fl, ordy);
        int lat;
        cyc++;
        if (fl) begin
            m_full = 0; m_pend = 0;
        end else if (m_pend) begin
            if (cyc == m_due) begin m_pend = 0; m_full = 1; end
        end else if (iv && (!m_full || ordy)) begin
            m_word = ref_decode(op, f);
            lat    = ref_latency(op, f);
            if (lat == 1) m_full = 1;
            else begin m_full = 0; m_pend = 1; m_due = cyc + lat; end
        end else if (m_full && ordy) begin
            m_full = 0;
        end
    endtask

    // One clock: drive at the negedge, check in_ready, clock, check state.
    task automatic drive(input bit iv, input logic [5:0] op, f, input bit fl, ordy);
        bus.in_valid = iv; bus.op = op; bus.funct = f; bus.flush = fl; bus.out_ready = ordy;
        #1;
        chk("in_ready", 32'(bus.in_ready), 32'(!m_pend && (!m_full || ordy)));
        @(posedge clk);
        model_edge(iv, op, f, fl, ordy);
        @(negedge clk);
        chk("out_valid", 32'(bus.out_valid), 32'(m_full));
        chk("busy", 32'(bus.busy), 32'(m_pend));
        chk("ctrl_word", 32'(obs()), 32'(m_word));
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        bus.in_valid = 0; bus.op = '0; bus.funct = '0; bus.flush = 0; bus.out_ready = 0;
        model_reset();
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    vec_t vecs[20];
    logic [5:0] rnd_ops[16];
    logic [5:0] rnd_fns[11];

    initial begin
        int lat;
        exp_t e_addi;
        cyc = 0;

        vecs[0]  = '{6'd35, 6'h00, mk(1,0,2'b01,0,0,1,0,0,2'b00,c_ADD,0)};   // LW
        vecs[1]  = '{6'd43, 6'h00, mk(0,0,2'b01,0,1,0,0,0,2'b00,c_ADD,0)};   // SW
        vecs[2]  = '{6'd8,  6'h00, mk(1,0,2'b01,0,0,0,0,0,2'b00,c_ADD,0)};   // ADDI
        vecs[3]  = '{6'd9,  6'h00, mk(1,0,2'b01,0,0,0,0,0,2'b00,c_ADDU,0)};  // ADDIU
        vecs[4]  = '{6'd10, 6'h00, mk(1,0,2'b01,0,0,0,0,0,2'b00,c_SLT,0)};   // SLTI
        vecs[5]  = '{6'd12, 6'h00, mk(1,0,2'b10,0,0,0,0,0,2'b00,c_AND,0)};   // ANDI
        vecs[6]  = '{6'd13, 6'h00, mk(1,0,2'b10,0,0,0,0,0,2'b00,c_OR,0)};    // ORI
        vecs[7]  = '{6'd14, 6'h00, mk(1,0,2'b10,0,0,0,0,0,2'b00,c_XOR,0)};   // XORI
        vecs[8]  = '{6'd15, 6'h00, mk(1,0,2'b10,0,0,0,0,0,2'b00,c_LUI,0)};   // LUI
        vecs[9]  = '{6'd4,  6'h00, mk(0,0,2'b00,1,0,0,0,0,2'b00,c_SUB,0)};   // BEQ
        vecs[10] = '{6'd5,  6'h00, mk(0,0,2'b00,1,0,0,0,0,2'b00,c_SUB,0)};   // BNE
        vecs[11] = '{6'd2,  6'h00, mk(0,0,2'b00,0,0,0,1,0,2'b00,c_NOP,0)};   // J
        vecs[12] = '{6'd3,  6'h00, mk(1,0,2'b00,0,0,0,1,1,2'b00,c_NOP,0)};   // JAL
        vecs[13] = '{6'd0,  6'h20, mk(1,1,2'b00,0,0,0,0,0,2'b00,c_RT,0)};    // ADD
        vecs[14] = '{6'd0,  6'h10, mk(1,1,2'b00,0,0,0,0,0,2'b00,c_RT,0)};    // MFHI
        vecs[15] = '{6'd0,  6'h11, mk(0,0,2'b00,0,0,0,0,0,2'b10,c_RT,0)};    // MTHI
        vecs[16] = '{6'd0,  6'h13, mk(0,0,2'b00,0,0,0,0,0,2'b01,c_RT,0)};    // MTLO
        vecs[17] = '{6'd0,  6'h08, mk(0,0,2'b00,0,0,0,1,0,2'b00,c_RT,0)};    // JR
        vecs[18] = '{6'd63, 6'h00, mk(0,0,2'b00,0,0,0,0,0,2'b00,c_NOP,1)};   // reserved
        vecs[19] = '{6'd1,  6'h00, mk(0,0,2'b00,0,0,0,0,0,2'b00,c_NOP,1)};   // reserved
        e_addi = vecs[2].exp;

        rnd_ops = '{6'd0, 6'd0, 6'd0, 6'd2, 6'd3, 6'd4, 6'd5, 6'd8,
                    6'd9, 6'd10, 6'd12, 6'd13, 6'd14, 6'd15, 6'd35, 6'd43};
        rnd_fns = '{6'h20, 6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19,
                    6'h1a, 6'h1b, 6'h08, 6'h22};

        // Reset state.
        do_reset();
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_ctrl", 32'(obs()), 32'd0);
        @(negedge clk);

        // Decode table, back-to-back with out_ready held high.
        for (int i = 0; i < 20; i++) begin
            drive(1, vecs[i].op, vecs[i].funct, 0, 1);
            chk($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'd1);
            chk($sformatf("vec%0d_word", i), 32'(obs()), 32'(vecs[i].exp));
        end
        drive(0, 6'd0, 6'd0, 0, 1);
        chk("drain_valid", 32'(bus.out_valid), 32'd0);

        // DIV latency: out_valid must rise exactly DIV_CYCLES after accept.
        drive(1, 6'd0, 6'h1a, 0, 0);
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            drive(1, 6'd8, 6'd0, 0, 0);
            lat++;
        end
        chk("div_latency", 32'(lat), 32'(DIV_CYCLES));
        chk("div_hilo", 32'(bus.hilowrite), 32'b11);

        // Stall in FULL, then back-to-back load of the waiting ADDI.
        for (int i = 0; i < 5; i++) begin
            drive(1, 6'd8, 6'd0, 0, 0);
            chk("stall_valid", 32'(bus.out_valid), 32'd1);
            chk("stall_hilo", 32'(bus.hilowrite), 32'b11);
        end
        drive(1, 6'd8, 6'd0, 0, 1);
        chk("b2b_valid", 32'(bus.out_valid), 32'd1);
        chk("b2b_word", 32'(obs()), 32'(e_addi));

        // MULT accepted, flushed two cycles later: no late out_valid.
        drive(1, 6'd0, 6'h18, 0, 1);
        drive(0, 6'd0, 6'd0, 0, 1);
        drive(0, 6'd0, 6'd0, 1, 1);
        chk("flush_busy", 32'(bus.busy), 32'd0);
        chk("flush_valid", 32'(bus.out_valid), 32'd0);
        #1;
        chk("flush_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            drive(0, 6'd0, 6'd0, 0, 1);
            chk("flush_no_late_valid", 32'(bus.out_valid), 32'd0);
        end
        // Flush with a simultaneous accept drops the instruction.
        drive(1, 6'd35, 6'd0, 1, 1);
        chk("flush_drop_valid", 32'(bus.out_valid), 32'd0);

        // Asynchronous reset in the middle of a DIV.
        drive(1, 6'd0, 6'h1b, 0, 1);
        drive(0, 6'd0, 6'd0, 0, 1);
        #2;
        resetn = 1'b0;
        #1;
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_ctrl", 32'(obs()), 32'd0);
        @(negedge clk);
        do_reset();

        // Random traffic against the reference model.
        for (int n = 0; n < 1500; n++) begin
            logic [5:0] op, f;
            op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : rnd_ops[$urandom_range(0, 15)];
            f  = ($urandom_range(0, 7) == 0) ? 6'($urandom) : rnd_fns[$urandom_range(0, 10)];
            drive($urandom_range(0, 3) != 0, op, f,
                  $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
